// File: rtl/td4_exec_stage.sv
// TD4 execute/writeback stage: adds selector output to the immediate and
// writes the sum into A, B, OUT and/or PC; holds the carry flag and steps PC.
// Optional macro TD4_OUT_STROBE_EN adds OUT_STB, a one-cycle pulse after
// every executed OUT write.
module td4_exec_stage #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] IM,
  input  logic [3:0]   LD,
  output logic [N-1:0] REG_A,
  output logic [N-1:0] REG_B,
  output logic [N-1:0] OUT,
  output logic [P-1:0] PC,
`ifdef TD4_OUT_STROBE_EN
  output logic         OUT_STB,
`endif
  output logic         CARRY
);

  localparam int unsigned SumW = N + 1;

  logic [SumW-1:0] sum_c;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    out_q, out_d;
  logic [P-1:0]    pc_q, pc_d;
  logic            carry_q, carry_d;
`ifdef TD4_OUT_STROBE_EN
  logic            stb_q, stb_d;
`endif

  // Adder: carry-out lands in the top bit.
  assign sum_c = SumW'(Y) + SumW'(IM);

  // Next-state: loads and PC/carry update only on executed cycles.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    pc_d    = pc_q;
    carry_d = carry_q;
`ifdef TD4_OUT_STROBE_EN
    stb_d   = 1'b0;
`endif
    if (EN) begin
      if (LD[0]) a_d   = sum_c[N-1:0];
      if (LD[1]) b_d   = sum_c[N-1:0];
      if (LD[2]) out_d = sum_c[N-1:0];
      if (LD[3]) pc_d  = sum_c[P-1:0];
      else       pc_d  = pc_q + P'(1);
      carry_d = sum_c[N];
`ifdef TD4_OUT_STROBE_EN
      stb_d   = LD[2];
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
`ifdef TD4_OUT_STROBE_EN
      stb_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
`ifdef TD4_OUT_STROBE_EN
      stb_q   <= stb_d;
`endif
    end
  end

  assign REG_A = a_q;
  assign REG_B = b_q;
  assign OUT   = out_q;
  assign PC    = pc_q;
  assign CARRY = carry_q;
`ifdef TD4_OUT_STROBE_EN
  assign OUT_STB = stb_q;
`endif

endmodule
